raw_unpacker: RTL

Converts the camera receiver's per-cycle byte beats into parallel pixels with x/y coordinates, sitting between `camera` and `arbiter` in the MIPI clock domain. It replaces the fixed RAW8 byte pass-through with a parametrised unpacker. It accepts RAW8 and RAW10 CSI-2 payloads, realigns RAW10's 5-byte groups across beat boundaries, and drops unsupported data types with a sticky flag. Output pixels are uniform `PIXEL_WIDTH` MSB-justified words, so downstream logic is format-agnostic.

---
 rtl/mipi_pkg.sv | 9 +
 rtl/raw10_aligner.sv | 34 +++
 rtl/raw_unpacker.sv | 87 ++++++++
 3 files changed

// File: rtl/mipi_pkg.sv
// mipi_pkg: CSI-2 raw data-type constants and format decode shared by the raw unpacker.
package mipi_pkg;
  localparam logic [5:0] DT_RAW8 = 6'h2A;
  localparam logic [5:0] DT_RAW10 = 6'h2B;
  typedef enum logic [1:0] {FMT_NONE, FMT_RAW8, FMT_RAW10} raw_format_t;
  function automatic raw_format_t dt_format(input logic [5:0] dt);
    return dt == DT_RAW8 ? FMT_RAW8 : dt == DT_RAW10 ? FMT_RAW10 : FMT_NONE;
  endfunction
endpackage

// File: rtl/raw10_aligner.sv
// raw10_aligner: 8-byte accumulator that realigns RAW10 5-byte groups across 4-byte beats.
module raw10_aligner (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_clear,
  input  logic        i_beat,
  input  logic [31:0] i_data,
  output logic        o_emit,
  output logic [39:0] o_group
);
  logic [63:0] r_acc, w_buf;
  logic [2:0] r_count, w_count;
  logic [3:0] w_total;
  // a clear in the same cycle as a beat empties the buffer before the beat lands
  assign w_count = i_clear ? 3'd0 : r_count;
  assign w_total = {1'b0, w_count} + 4'd4;
  assign w_buf = (i_clear ? 64'd0 : r_acc) | ({32'd0, i_data} << {w_count, 3'b000});
  assign o_emit = i_beat & (w_total >= 4'd5);
  assign o_group = w_buf[39:0];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_acc <= '0;
      r_count <= '0;
    end else if (o_emit) begin
      r_acc <= w_buf >> 40;
      r_count <= 3'(w_total - 4'd5);
    end else if (i_beat) begin
      r_acc <= w_buf;
      r_count <= w_total[2:0];
    end else if (i_clear) begin
      r_acc <= '0;
      r_count <= '0;
    end
endmodule

// File: rtl/raw_unpacker.sv
// raw_unpacker: CSI-2 RAW8/RAW10 beats to 4 MSB-justified pixels with x/y coordinates.
// RAW10 support (raw10_aligner) is built only when RAW_UNPACKER_RAW10_EN is defined.
module raw_unpacker
  import mipi_pkg::*;
#(
  parameter int IN_BYTES = 4,
  parameter int PIXEL_WIDTH = 10,
  parameter int COORD_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [IN_BYTES*8-1:0]    image_data,
  input  logic [5:0]               image_data_type,
  input  logic                     image_data_enable,
  input  logic                     frame_start,
  input  logic                     line_start,
  output logic [4*PIXEL_WIDTH-1:0] pixels,
  output logic                     pixel_valid,
  output logic [COORD_WIDTH-1:0]   pixel_x,
  output logic [COORD_WIDTH-1:0]   pixel_y,
  output logic                     unsupported
);
  raw_format_t w_fmt;
  logic r_line_active, r_first_line;
  logic [COORD_WIDTH-1:0] r_x, w_x;
  logic w_beat, w_clear, w_raw8, w_raw10, w_bad, w_emit10, w_emit;
  logic [4*PIXEL_WIDTH-1:0] w_pix8, w_pix10;
  assign w_fmt = dt_format(image_data_type);
  // beats are ignored after reset until a line has started
  assign w_beat = image_data_enable & (r_line_active | line_start);
  assign w_clear = line_start | frame_start;
  assign w_raw8 = w_beat & (w_fmt == FMT_RAW8);
  assign w_bad = w_beat & ~w_raw8 & ~w_raw10;
  assign w_emit = w_raw8 | w_emit10;
  assign w_x = w_clear ? '0 : r_x;
  for (genvar n = 0; n < 4; n++) begin : g_pix8
    assign w_pix8[n*PIXEL_WIDTH +: PIXEL_WIDTH] = PIXEL_WIDTH'(image_data[n*8 +: 8]) << (PIXEL_WIDTH - 8);
  end
`ifdef RAW_UNPACKER_RAW10_EN
  logic [39:0] w_group;
  assign w_raw10 = w_beat & (w_fmt == FMT_RAW10);
  raw10_aligner u_aligner (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clear (w_clear),
    .i_beat  (w_raw10),
    .i_data  (image_data[31:0]),
    .o_emit  (w_emit10),
    .o_group (w_group)
  );
  for (genvar n = 0; n < 4; n++) begin : g_pix10
    assign w_pix10[n*PIXEL_WIDTH +: PIXEL_WIDTH] =
      PIXEL_WIDTH'({w_group[n*8 +: 8], w_group[32+2*n +: 2]}) << (PIXEL_WIDTH - 10);
  end
`else
  assign w_raw10 = 1'b0;
  assign w_emit10 = 1'b0;
  assign w_pix10 = '0;
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pixels <= '0;
      pixel_valid <= 1'b0;
      pixel_x <= '0;
      pixel_y <= '0;
      unsupported <= 1'b0;
      r_x <= '0;
      r_line_active <= 1'b0;
      r_first_line <= 1'b1;
    end else begin
      pixel_valid <= w_emit;
      if (w_emit) begin
        pixels <= w_raw8 ? w_pix8 : w_pix10;
        pixel_x <= w_x;
        r_x <= w_x + COORD_WIDTH'(4);
      end else if (w_clear) begin
        pixel_x <= '0;
        r_x <= '0;
      end
      if (line_start) begin
        pixel_y <= (r_first_line | frame_start) ? '0 : pixel_y + COORD_WIDTH'(1);
        r_line_active <= 1'b1;
      end
      r_first_line <= line_start ? 1'b0 : (frame_start | r_first_line);
      unsupported <= w_bad | (unsupported & ~frame_start);
    end
endmodule
